// File: rtl/fifo_sync_ram_ext_pkg.sv
// Shared types and helpers for the RAM-backed first-word-fall-through FIFO.
package fifo_sync_ram_ext_pkg;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'b00,
        LVL_INC  = 2'b01,
        LVL_DEC  = 2'b10
    } lvl_op_e;

    function automatic lvl_op_e lvl_op(input logic wr_acc, input logic rd_acc);
        lvl_op_e op;
        case ({wr_acc, rd_acc})
            2'b10:   op = LVL_INC;
            2'b01:   op = LVL_DEC;
            default: op = LVL_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fifo_sync_ram_ext_ram_sdp.sv
// Simple dual-port RAM, one write port and one registered read port.
module ram_sdp #(
    parameter int AW    = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_ena,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ena
);

    logic [WIDTH-1:0] mem_r [2**AW];

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_ena) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, one cycle of latency
    always_ff @(posedge clk) begin
        if (rd_ena) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_ram_ext.sv
// FWFT synchronous FIFO on a simple-dual-port RAM with level reporting,
// thresholds, flush, and sticky overflow/underflow flags.
module fifo_sync_ram_ext
    import fifo_sync_ram_ext_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int WIDTH     = 16,
    parameter int AF_THRESH = 192,
    parameter int AE_THRESH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_ena,
    output logic                     wr_full,
    output logic                     wr_afull,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     rd_ena,
    output logic                     rd_empty,
    output logic                     rd_aempty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_ovf,
    output logic                     err_udf,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic          head_valid_r;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          ram_re_s;
    logic          ovf_set_s;
    logic          udf_set_s;
    logic [AW:0]   ram_words_s;
    logic [AW:0]   level_nxt_s;
    lvl_op_e       lvl_op_s;

    // Request qualification; the head word lives in the RAM output register,
    // so only words beyond it are still waiting in the array.
    always_comb begin
        wr_acc_s    = wr_ena & ~wr_full & ~flush;
        rd_acc_s    = rd_ena & head_valid_r & ~flush;
        ovf_set_s   = wr_ena & wr_full & ~flush;
        udf_set_s   = rd_ena & ~head_valid_r & ~flush;
        ram_words_s = level - (AW+1)'(head_valid_r);
        ram_re_s    = (rd_acc_s | ~head_valid_r) & (ram_words_s != (AW+1)'(0)) & ~flush;
        lvl_op_s    = lvl_op(wr_acc_s, rd_acc_s);
    end

    // Next fill level
    always_comb begin
        level_nxt_s = level;
        case (lvl_op_s)
            LVL_INC: level_nxt_s = level + (AW+1)'(1);
            LVL_DEC: level_nxt_s = level - (AW+1)'(1);
            default: level_nxt_s = level;
        endcase
    end

    // Pointers, head-valid, level, status and error flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= AW'(0);
            rd_ptr_r     <= AW'(0);
            head_valid_r <= 1'b0;
            level        <= (AW+1)'(0);
            wr_full      <= 1'b0;
            wr_afull     <= 1'b0;
            rd_aempty    <= 1'b1;
            err_ovf      <= 1'b0;
            err_udf      <= 1'b0;
        end else begin
            err_ovf <= (err_ovf & ~err_clr) | ovf_set_s;
            err_udf <= (err_udf & ~err_clr) | udf_set_s;
            if (flush) begin
                wr_ptr_r     <= AW'(0);
                rd_ptr_r     <= AW'(0);
                head_valid_r <= 1'b0;
                level        <= (AW+1)'(0);
                wr_full      <= 1'b0;
                wr_afull     <= 1'b0;
                rd_aempty    <= 1'b1;
            end else begin
                if (wr_acc_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (ram_re_s) begin
                    rd_ptr_r     <= rd_ptr_r + AW'(1);
                    head_valid_r <= 1'b1;
                end else if (rd_acc_s) begin
                    head_valid_r <= 1'b0;
                end
                level     <= level_nxt_s;
                wr_full   <= (level_nxt_s == (AW+1)'(DEPTH));
                wr_afull  <= (level_nxt_s >= (AW+1)'(AF_THRESH));
                rd_aempty <= (level_nxt_s <= (AW+1)'(AE_THRESH));
            end
        end
    end

    assign rd_empty = ~head_valid_r;

    ram_sdp #(
        .AW    (AW),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_data),
        .wr_ena  (wr_acc_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data),
        .rd_ena  (ram_re_s)
    );

endmodule
